bitty_fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the bitty control unit. Reads 16-bit instructions from a synchronous instruction memory, holds each one stable on the control unit's instruction input, and asserts `run` for the full four-state execute sequence. Advances the program counter when the control unit reports `done`. Stops after the configured last address.

---
 rtl/bitty_pkg.sv | 15 +
 rtl/bitty_sat_counter.sv | 31 +++
 rtl/bitty_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch path: instruction width and fetch FSM encoding.
package bitty_pkg;

  localparam int unsigned INSTR_WIDTH = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLatch = 3'd2,
    StExec  = 3'd3,
    StHalt  = 3'd4,
    StPause = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/bitty_sat_counter.sv
// 16-bit counter that saturates at all-ones; synchronous clear wins over increment.
module bitty_sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch stage feeding the bitty control unit: fetch, latch, hold for execute, advance.
// Optional single-step mode (step port, PAUSE state) is enabled by defining FETCH_STEP_EN.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned END_ADDR   = 2**ADDR_WIDTH - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   run,
  input  logic                   done,
`ifdef FETCH_STEP_EN
  input  logic                   step,
`endif
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [15:0]            retired,
  output logic                   halted
);

  localparam logic [ADDR_WIDTH-1:0] EndAddr = ADDR_WIDTH'(END_ADDR);

  fetch_state_e                 state_d, state_q;
  logic [ADDR_WIDTH-1:0]        pc_d, pc_q;
  logic [INSTR_WIDTH-1:0]       instr_d, instr_q;
  logic                         retire;
  logic                         restart;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    retire  = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          restart = 1'b1;
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        instr_d = mem_rdata;
        state_d = StExec;
      end
      StExec: begin
        if (done) begin
          retire = 1'b1;
          // Last-address check first so pc never wraps past END_ADDR.
          if (pc_q == EndAddr) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_q + 1'b1;
`ifdef FETCH_STEP_EN
            state_d = StPause;
`else
            state_d = StFetch;
`endif
          end
        end
      end
`ifdef FETCH_STEP_EN
      StPause: begin
        if (step) begin
          state_d = StFetch;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  bitty_sat_counter u_retired (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .inc   (retire),
    .count (retired)
  );

  // Strobes decode straight from the state register; done never reaches run combinationally.
  assign mem_rd_en = (state_q == StFetch);
  assign mem_addr  = pc_q;
  assign run       = (state_q == StExec);
  assign halted    = (state_q == StHalt);
  assign pc        = pc_q;
  assign instr     = instr_q;

endmodule
